// File: rtl/tohost_pkg.sv
// Shared types and decode helpers for the HTIF tohost monitor.
// Contents:
//   state_e    monitor FSM states
//   reason_e   failure reason codes driven on the reason output
//   decode_t   classification of one complete 64-bit tohost value
//   decode_value()  rule set applied to every complete tohost value
package tohost_pkg;

  typedef enum logic [1:0] {
    StRun,
    StHalf,
    StPass,
    StFail
  } state_e;

  typedef enum logic [1:0] {
    RsnNone      = 2'd0,
    RsnExit      = 2'd1,
    RsnTimeout   = 2'd2,
    RsnMalformed = 2'd3
  } reason_e;

  // HTIF command layout: device in [63:56], command in [55:48].
  localparam int unsigned DevMsb = 63;
  localparam int unsigned DevLsb = 56;
  localparam int unsigned CmdMsb = 55;
  localparam int unsigned CmdLsb = 48;

  localparam logic [7:0] DevConsole = 8'd1;
  localparam logic [7:0] CmdPutchar = 8'd1;

  localparam logic [7:0] MaskFull = 8'hFF;
  localparam logic [7:0] MaskLo   = 8'h0F;
  localparam logic [7:0] MaskHi   = 8'hF0;

  typedef struct packed {
    logic    term;    // value ends the test
    logic    pass;    // only meaningful with term
    logic    cons;    // console putchar, test continues
    reason_e reason;
  } decode_t;

  function automatic decode_t decode_value(input logic [63:0] v, input logic console_en);
    decode_t d;
    logic    putchar;
    d        = '0;
    d.reason = RsnNone;
    putchar  = (v[DevMsb:DevLsb] == DevConsole) && (v[CmdMsb:CmdLsb] == CmdPutchar);
    if (v == '0) begin
      // Zero is the idle value written back by the host; nothing to do.
    end else if (putchar) begin
      if (console_en) begin
        d.cons = 1'b1;
      end else begin
        // A console request with no console attached is a protocol error.
        d.term   = 1'b1;
        d.reason = RsnMalformed;
      end
    end else if (v[0]) begin
      d.term = 1'b1;
      if (v[63:1] == '0) begin
        d.pass = 1'b1;
      end else begin
        d.reason = RsnExit;
      end
    end else begin
      d.term   = 1'b1;
      d.reason = RsnMalformed;
    end
    return d;
  endfunction

endpackage

// File: rtl/tohost_watchdog.sv
// Saturating progress watchdog.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   clear_i   restart the count (progress seen)
//   en_i      count this cycle
//   expire_o  count reaches Limit on this cycle's increment (or already sits there)
// Limit == 0 disables the watchdog entirely.
module tohost_watchdog #(
  parameter int unsigned Width = 32,
  parameter int unsigned Limit = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [Width-1:0] LimitW = Width'(Limit);
  localparam logic             Active = (Limit != 0);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && Active && (count_q != LimitW)) begin
      count_d = count_q + Width'(1);
    end
  end

  // Staying asserted while saturated lets an expiry that lost to another
  // event fire again on the next counted cycle.
  assign expire_o = Active && en_i && !clear_i && (count_q >= LimitW - Width'(1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/tohost_monitor.sv
// Snoops the harness memory write channel for stores to the HTIF tohost word
// and reports test termination (finish / sticky failure + reason), with a
// progress watchdog for hung cases. Purely passive: never drives ready.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   wr_valid, wr_ready    snooped handshake; a beat fires on valid && ready
//   wr_addr/data/mask     snooped write beat
//   progress              one-cycle pulse per retired instruction
//   finish                test ended with exit code 0
//   failure               test ended with nonzero exit, malformed tohost or timeout
//   reason                0 none, 1 nonzero exit, 2 timeout, 3 malformed
//   exit_code             data[32:1] of the terminating tohost value
//   cons_valid/cons_char  console putchar strobe (only with TOHOST_CONSOLE_EN)
// Optional feature macro: TOHOST_CONSOLE_EN.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h8000_1000,
  parameter int unsigned       WDOG_CYCLES = 100000,
  parameter int unsigned       WDOG_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_valid,
  input  logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  input  logic [7:0]        wr_mask,
  input  logic              progress,
  output logic              finish,
  output logic              failure,
  output logic [1:0]        reason,
  output logic [31:0]       exit_code
`ifdef TOHOST_CONSOLE_EN
  ,
  output logic              cons_valid,
  output logic [7:0]        cons_char
`endif
);

`ifdef TOHOST_CONSOLE_EN
  localparam logic ConsoleEn = 1'b1;
`else
  localparam logic ConsoleEn = 1'b0;
`endif

  state_e      state_q, state_d;
  reason_e     reason_q, reason_d;
  logic [31:0] exit_q, exit_d;
  logic [31:0] lo_q, lo_d;
  logic        cons_valid_q, cons_valid_d;
  logic [7:0]  cons_char_q, cons_char_d;

  logic        hit;
  logic        live;
  logic        expire;
  logic        eval_now;
  logic [63:0] eval_val;
  decode_t     dec;

  assign hit  = wr_valid && wr_ready && (wr_addr == TOHOST_ADDR) && (wr_mask != '0);
  assign live = (state_q == StRun) || (state_q == StHalf);

  // In HALF the complete value is the new high half over the latched low half.
  assign eval_val = (state_q == StHalf) ? {wr_data[63:32], lo_q} : wr_data;
  assign dec      = decode_value(eval_val, ConsoleEn);

  tohost_watchdog #(
    .Width(WDOG_W),
    .Limit(WDOG_CYCLES)
  ) u_watchdog (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (progress),
    .en_i    (live),
    .expire_o(expire)
  );

  always_comb begin
    state_d      = state_q;
    reason_d     = reason_q;
    exit_d       = exit_q;
    lo_d         = lo_q;
    cons_valid_d = 1'b0;
    cons_char_d  = cons_char_q;
    eval_now     = 1'b0;

    if (live) begin
      if (hit) begin
        if ((state_q == StRun) && (wr_mask == MaskFull)) begin
          eval_now = 1'b1;
        end else if ((state_q == StRun) && (wr_mask == MaskLo)) begin
          lo_d    = wr_data[31:0];
          state_d = StHalf;
        end else if ((state_q == StHalf) && (wr_mask == MaskHi)) begin
          eval_now = 1'b1;
          state_d  = StRun;
        end else begin
          state_d  = StFail;
          reason_d = RsnMalformed;
        end
      end else if (expire) begin
        // A hit in the same cycle takes precedence over the timeout.
        state_d  = StFail;
        reason_d = RsnTimeout;
        exit_d   = '0;
      end
    end

    if (eval_now && dec.term) begin
      state_d  = dec.pass ? StPass : StFail;
      reason_d = dec.reason;
      exit_d   = eval_val[32:1];
    end
    if (eval_now && dec.cons) begin
      cons_valid_d = 1'b1;
      cons_char_d  = eval_val[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StRun;
      reason_q     <= RsnNone;
      exit_q       <= '0;
      lo_q         <= '0;
      cons_valid_q <= 1'b0;
      cons_char_q  <= '0;
    end else begin
      state_q      <= state_d;
      reason_q     <= reason_d;
      exit_q       <= exit_d;
      lo_q         <= lo_d;
      cons_valid_q <= cons_valid_d;
      cons_char_q  <= cons_char_d;
    end
  end

  assign finish    = (state_q == StPass);
  assign failure   = (state_q == StFail);
  assign reason    = reason_q;
  assign exit_code = exit_q;

`ifdef TOHOST_CONSOLE_EN
  assign cons_valid = cons_valid_q;
  assign cons_char  = cons_char_q;
`else
  logic unused_cons;
  assign unused_cons = cons_valid_q ^ (^cons_char_q);
`endif

endmodule
